// File: rtl/ifu_npc_if.sv
// ifu_npc_if: instruction-memory read handshake between fetch unit and memory
interface ifu_npc_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/ifu_npc.sv
// ifu_npc: instruction fetch with next-PC selection, FETCH/EXEC/HALT sequencing
module ifu_npc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst_n,
  ifu_npc_if.master        imem,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic [2:0]       branch,
  input  logic [1:0]       jump,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             stall,
  output logic             align_err,
  output logic [31:0]      retired
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t      state;
  logic        taken;
  logic [31:0] boff;
  logic [31:0] npc;
  assign pc_plus4    = pc + 32'd4;
  assign imem.req    = !rst_n || state == FETCH;
  assign imem.addr   = pc;
  assign instr_valid = rst_n && state == EXEC;
  assign boff        = {{14{instr[15]}}, instr[15:0], 2'b00};
  // signed compares against zero reduce to sign bit and zero test
  always_comb begin
    taken = branch == 3'b001 ? rs_data == rt_data :
            branch == 3'b010 ? rs_data != rt_data :
            branch == 3'b011 ? !rs_data[31] :
            branch == 3'b100 ? !rs_data[31] && |rs_data :
            branch == 3'b101 ? rs_data[31] || ~|rs_data :
            branch == 3'b110 ? rs_data[31] : 1'b0;
    npc   = jump == 2'b01 ? {pc_plus4[31:28], instr[25:0], 2'b00} :
            jump == 2'b10 ? rs_data :
            taken         ? pc_plus4 + boff : pc_plus4;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      instr     <= '0;
      retired   <= '0;
      align_err <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem.ack) begin
          instr <= imem.rdata;
          state <= EXEC;
        end
        EXEC: if (!stall) begin
          if (npc[1:0] != 2'b00) begin
            align_err <= 1'b1;
            state     <= HALT;
          end else begin
            pc      <= npc;
            retired <= retired + 32'd1;
            state   <= FETCH;
          end
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: doc/ifu_npc.md
IFU_NPC -- requirements
Module: ifu_npc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the PC loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  word address for the request; equals pc.
REQ-006 imem_ack  in  1  read data valid this cycle.
REQ-007 imem_rdata  in  32  instruction word; sampled only when imem_ack=1.
REQ-008 instr  out  32  latched instruction for decode/ctrl.
REQ-009 instr_valid  out  1  instr is executing this cycle.
REQ-010 pc  out  32  address of instr.
REQ-011 pc_plus4  out  32  pc+4, link value for jal/jalr.
REQ-012 branch  in  3  branch code from ctrl: 000 none, 001 beq, 010 bne, 011 bgez, 100 bgtz, 101 blez, 110 bltz, 111 none.
REQ-013 jump  in  2  jump code from ctrl: 00 none, 01 j/jal, 10 jr/jalr, 11 none.
REQ-014 rs_data, rt_data  in  32 each  register operands for compare and jr target.
REQ-015 stall  in  1  hold current instruction in EXEC.
REQ-016 align_err  out  1  sticky: misaligned next-PC detected.
REQ-017 retired  out  32  count of completed instructions.

Function
REQ-018 The block SHALL implement states FETCH, EXEC, HALT.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; instr_valid SHALL be 0.
REQ-020 In FETCH with imem_ack=1, instr SHALL capture imem_rdata and state SHALL become EXEC next cycle; with imem_ack=0, FETCH holds with no limit on wait.
REQ-021 Minimum fetch latency: ack in the first FETCH cycle gives instr_valid=1 on the following cycle.
REQ-022 In EXEC, imem_req SHALL be 0, instr_valid SHALL be 1, and branch/jump/rs_data/rt_data SHALL be sampled combinationally for next-PC.
REQ-023 In EXEC with stall=1, state, pc, instr and retired SHALL hold.
REQ-024 In EXEC with stall=0 and aligned next-PC, pc SHALL load next-PC, retired SHALL increment (mod 2^32, FFFF_FFFF wraps to 0), state SHALL become FETCH.
REQ-025 Next-PC priority: jump=01 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else jump=10 -> rs_data; else branch taken -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-026 Branch taken: beq rs==rt; bne rs!=rt; bgez rs>=0; bgtz rs>0; blez rs<=0; bltz rs<0; compares on rs are signed 32-bit.
REQ-027 All PC arithmetic SHALL be 32-bit modulo; pc=FFFF_FFFC gives pc_plus4=0000_0000.
REQ-028 pc_plus4 SHALL equal pc+4 in every state.
REQ-029 If next-PC[1:0]!=0 in EXEC with stall=0, pc SHALL hold, align_err SHALL set, retired SHALL not increment, state SHALL become HALT.
REQ-030 In HALT, imem_req=0, instr_valid=0, all registers hold until reset.
REQ-031 stall is ignored in FETCH and HALT.

Reset
REQ-032 With rst_n=0 at a clock edge: pc=RESET_PC, instr=0, retired=0, align_err=0, state=FETCH, regardless of current state.
REQ-033 Reset asserted during an outstanding FETCH SHALL discard any imem_ack in that cycle; fetch restarts at RESET_PC on the first cycle after rst_n=1.
REQ-034 Outputs during reset cycles SHALL follow FETCH decode of reset state (imem_req=1, imem_addr=RESET_PC).

Verification
REQ-035 Sequential: reset, ack at 1 cycle each, instr=0 (branch=000, jump=00) -> pc 3000, 3004, 3008; retired=3 after third EXEC.
REQ-036 Branch: pc=3010, instr[15:0]=FFFE, branch=001, rs=rt=5 -> next pc=300C; with rs=5, rt=6 -> 3014.
REQ-037 Signed compare: branch=100, rs=8000_0000 -> not taken; rs=0000_0001 -> taken.
REQ-038 Jumps: pc=3000, jump=01, instr[25:0]=0000C40 -> pc=0000_3100; jump=10, rs=0000_3204 with branch=001 taken simultaneously -> pc=3204.
REQ-039 Wait/stall: imem_ack delayed 3 cycles then stall=1 for 2 EXEC cycles -> instr_valid high 3 cycles, retired increments once, instr constant.
REQ-040 Error/reset: jump=10, rs=0000_3002 -> align_err=1, HALT, pc unchanged; then rst_n=0 one cycle -> pc=3000, align_err=0, imem_req=1.
